// File: rtl/fir_mac_sched.sv
// fir_mac_sched: NUM_CH-channel first-order IIR/FIR section sharing one signed multiplier.
// Define FIR_MAC_SCHED_ROUND_EN to round each product half-up instead of flooring it.
module fir_mac_sched #(
  parameter int NUM_CH         = 4,
  parameter int INOUT_WIDTH    = 16,
  parameter int INTERNAL_WIDTH = 18,
  parameter logic signed [INTERNAL_WIDTH-1:0] COEF_B0_RST = 18'sd131071,
  parameter logic signed [INTERNAL_WIDTH-1:0] COEF_B1_RST = -18'sd131072,
  parameter logic signed [INTERNAL_WIDTH-1:0] COEF_A1_RST = 18'sd0,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [CH_W-1:0]                  in_ch_i,
  input  logic signed [INOUT_WIDTH-1:0]    in_data_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [CH_W-1:0]                  out_ch_o,
  output logic signed [INOUT_WIDTH-1:0]    out_data_o,
  input  logic                             cfg_we_i,
  input  logic [1:0]                       cfg_sel_i,
  input  logic signed [INTERNAL_WIDTH-1:0] cfg_data_i,
  input  logic                             cfg_commit_i,
  output logic                             commit_pending_o
);

  localparam int PROD_W = INOUT_WIDTH + INTERNAL_WIDTH;
  localparam int SHIFT  = INTERNAL_WIDTH - 1;
  localparam logic signed [PROD_W-1:0] ACC_MAX =
    (PROD_W'(1) << (INTERNAL_WIDTH - 1)) - PROD_W'(1);
  localparam logic signed [PROD_W-1:0] ACC_MIN = ~ACC_MAX;
  localparam logic signed [INTERNAL_WIDTH-1:0] OUT_MAX =
    (INTERNAL_WIDTH'(1) << (INOUT_WIDTH - 1)) - INTERNAL_WIDTH'(1);
  localparam logic signed [INTERNAL_WIDTH-1:0] OUT_MIN = ~OUT_MAX;
`ifdef FIR_MAC_SCHED_ROUND_EN
  localparam logic signed [PROD_W-1:0] RND = PROD_W'(1) << (INTERNAL_WIDTH - 2);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_B0,
    ST_MUL_B1,
    ST_MUL_A1,
    ST_OUT
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_run;
  logic   w_in_ready;
  logic   w_accept;
  logic   w_apply;

  logic [CH_W-1:0]                  r_ch;
  logic signed [INOUT_WIDTH-1:0]    r_x;
  logic signed [INTERNAL_WIDTH-1:0] r_acc;
  logic                             r_out_valid;
  logic [CH_W-1:0]                  r_out_ch;
  logic signed [INOUT_WIDTH-1:0]    r_out_data;
  logic signed [INOUT_WIDTH-1:0]    r_x1 [NUM_CH];
  logic signed [INOUT_WIDTH-1:0]    r_y1 [NUM_CH];

  logic signed [INTERNAL_WIDTH-1:0] r_sh_b0, r_sh_b1, r_sh_a1;
  logic signed [INTERNAL_WIDTH-1:0] r_b0, r_b1, r_a1;
  logic                             r_pending;

  logic signed [INTERNAL_WIDTH-1:0] w_coef;
  logic signed [INOUT_WIDTH-1:0]    w_samp;
  logic signed [PROD_W-1:0]         w_samp_ext;
  logic signed [PROD_W-1:0]         w_coef_ext;
  logic signed [PROD_W-1:0]         w_prod;
  logic signed [PROD_W-1:0]         w_prod_adj;
  logic signed [PROD_W-1:0]         w_term;
  logic signed [PROD_W-1:0]         w_acc_ext;
  logic signed [PROD_W-1:0]         w_sum;
  logic signed [INTERNAL_WIDTH-1:0] w_acc_next;
  logic signed [INOUT_WIDTH-1:0]    w_out_next;

  // r_run holds in_ready_o low until the first edge after reset release.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= ST_IDLE;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_run   <= 1'b1;
    end
  end

  // A pending coefficient commit wins over accepting a new sample.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    w_apply      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pending) begin
          w_apply = 1'b1;
        end else begin
          w_in_ready = r_run;
          if (in_valid_i && r_run) begin
            w_accept     = 1'b1;
            w_next_state = ST_MUL_B0;
          end
        end
      end
      ST_MUL_B0: w_next_state = ST_MUL_B1;
      ST_MUL_B1: w_next_state = ST_MUL_A1;
      ST_MUL_A1: w_next_state = ST_OUT;
      ST_OUT:    if (out_ready_i) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_coef = r_a1;
    w_samp = r_y1[r_ch];
    case (r_state)
      ST_MUL_B0: begin
        w_coef = r_b0;
        w_samp = r_x;
      end
      ST_MUL_B1: begin
        w_coef = r_b1;
        w_samp = r_x1[r_ch];
      end
      default: ;
    endcase
  end

  assign w_samp_ext = {{INTERNAL_WIDTH{w_samp[INOUT_WIDTH-1]}}, w_samp};
  assign w_coef_ext = {{INOUT_WIDTH{w_coef[INTERNAL_WIDTH-1]}}, w_coef};
  assign w_prod     = w_samp_ext * w_coef_ext;
`ifdef FIR_MAC_SCHED_ROUND_EN
  assign w_prod_adj = w_prod + RND;
`else
  assign w_prod_adj = w_prod;
`endif
  assign w_term    = w_prod_adj >>> SHIFT;
  assign w_acc_ext = (r_state == ST_MUL_B0) ? '0
                   : {{INOUT_WIDTH{r_acc[INTERNAL_WIDTH-1]}}, r_acc};
  assign w_sum     = w_acc_ext + w_term;

  // Two-stage clamp: accumulator range first, then the output sample range.
  always_comb begin
    if (w_sum > ACC_MAX)      w_acc_next = ACC_MAX[INTERNAL_WIDTH-1:0];
    else if (w_sum < ACC_MIN) w_acc_next = ACC_MIN[INTERNAL_WIDTH-1:0];
    else                      w_acc_next = w_sum[INTERNAL_WIDTH-1:0];
    if (w_acc_next > OUT_MAX)      w_out_next = OUT_MAX[INOUT_WIDTH-1:0];
    else if (w_acc_next < OUT_MIN) w_out_next = OUT_MIN[INOUT_WIDTH-1:0];
    else                           w_out_next = w_acc_next[INOUT_WIDTH-1:0];
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_ch        <= '0;
      r_x         <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_data  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_x1[i] <= '0;
        r_y1[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_ch <= in_ch_i;
        r_x  <= in_data_i;
      end
      if (r_state == ST_MUL_B0 || r_state == ST_MUL_B1) begin
        r_acc <= w_acc_next;
      end
      if (r_state == ST_MUL_A1) begin
        r_out_valid <= 1'b1;
        r_out_ch    <= r_ch;
        r_out_data  <= w_out_next;
        r_x1[r_ch]  <= r_x;
        r_y1[r_ch]  <= w_out_next;
      end else if (r_state == ST_OUT && out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Shadow writes land immediately; the active set only changes while IDLE.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_sh_b0   <= COEF_B0_RST;
      r_sh_b1   <= COEF_B1_RST;
      r_sh_a1   <= COEF_A1_RST;
      r_b0      <= COEF_B0_RST;
      r_b1      <= COEF_B1_RST;
      r_a1      <= COEF_A1_RST;
      r_pending <= 1'b0;
    end else begin
      if (cfg_we_i) begin
        case (cfg_sel_i)
          2'd0:    r_sh_b0 <= cfg_data_i;
          2'd1:    r_sh_b1 <= cfg_data_i;
          2'd2:    r_sh_a1 <= cfg_data_i;
          default: ;
        endcase
      end
      if (w_apply) begin
        r_b0 <= r_sh_b0;
        r_b1 <= r_sh_b1;
        r_a1 <= r_sh_a1;
      end
      if (cfg_commit_i)  r_pending <= 1'b1;
      else if (w_apply)  r_pending <= 1'b0;
    end
  end

  assign in_ready_o       = w_in_ready;
  assign out_valid_o      = r_out_valid;
  assign out_ch_o         = r_out_ch;
  assign out_data_o       = r_out_data;
  assign commit_pending_o = r_pending;

endmodule

// File: tb/tb_fir_mac_sched.sv
// Self-checking bench for fir_mac_sched: directed table, corner sequences and a
// randomized run against an arithmetic reference model.
module tb_fir_mac_sched;

`ifdef FIR_MAC_SCHED_ROUND_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif
  localparam longint ACC_LO = -131072;
  localparam longint ACC_HI = 131071;

  logic               clk_i;
  logic               reset_ni;
  logic               in_valid_i;
  logic               in_ready_o;
  logic [1:0]         in_ch_i;
  logic signed [15:0] in_data_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [1:0]         out_ch_o;
  logic signed [15:0] out_data_o;
  logic               cfg_we_i;
  logic [1:0]         cfg_sel_i;
  logic signed [17:0] cfg_data_i;
  logic               cfg_commit_i;
  logic               commit_pending_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int mSh [3];
  int mB0, mB1, mA1;
  int mX1 [4];
  int mY1 [4];

  typedef struct {
    int ch;
    int data;
    int expData;
  } vec_t;

  fir_mac_sched dut (
    .clk_i            (clk_i),
    .reset_ni         (reset_ni),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_ch_i          (in_ch_i),
    .in_data_i        (in_data_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_ch_o         (out_ch_o),
    .out_data_o       (out_data_o),
    .cfg_we_i         (cfg_we_i),
    .cfg_sel_i        (cfg_sel_i),
    .cfg_data_i       (cfg_data_i),
    .cfg_commit_i     (cfg_commit_i),
    .commit_pending_o (commit_pending_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic longint floorDiv(longint a, longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint termOf(longint c, longint s);
    longint p;
    p = c * s;
`ifdef FIR_MAC_SCHED_ROUND_EN
    p = p + 65536;
`endif
    return floorDiv(p, 131072);
  endfunction

  function automatic longint clampTo(longint v, longint lo, longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int modelStep(int ch, int x);
    longint acc;
    int y;
    acc = clampTo(termOf(mB0, x), ACC_LO, ACC_HI);
    acc = clampTo(acc + termOf(mB1, mX1[ch]), ACC_LO, ACC_HI);
    acc = clampTo(acc + termOf(mA1, mY1[ch]), ACC_LO, ACC_HI);
    y = int'(clampTo(acc, -32768, 32767));
    mX1[ch] = x;
    mY1[ch] = y;
    return y;
  endfunction

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    mSh[0] = 131071; mSh[1] = -131072; mSh[2] = 0;
    mB0 = 131071; mB1 = -131072; mA1 = 0;
    for (int i = 0; i < 4; i++) begin
      mX1[i] = 0;
      mY1[i] = 0;
    end
  endtask

  task automatic doReset();
    reset_ni     = 1'b0;
    in_valid_i   = 1'b0;
    in_ch_i      = '0;
    in_data_i    = '0;
    out_ready_i  = 1'b1;
    cfg_we_i     = 1'b0;
    cfg_sel_i    = '0;
    cfg_data_i   = '0;
    cfg_commit_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_in_ready", in_ready_o, 0);
    checkOutput("rst_out_valid", out_valid_o, 0);
    reset_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("post_rst_in_ready", in_ready_o, 1);
    modelReset();
  endtask

  task automatic writeCoef(input int sel, input int val);
    cfg_sel_i  = 2'(sel);
    cfg_data_i = 18'(val);
    cfg_we_i   = 1'b1;
    @(posedge clk_i);
    #1;
    cfg_we_i = 1'b0;
    if (sel < 3) mSh[sel] = val;
  endtask

  // Commit issued in IDLE: pending for one cycle (ready low), applied the next.
  task automatic commitCoefs(input bit alsoWrite, input int sel, input int val);
    cfg_sel_i    = 2'(sel);
    cfg_data_i   = 18'(val);
    cfg_we_i     = alsoWrite;
    cfg_commit_i = 1'b1;
    @(posedge clk_i);
    #1;
    cfg_we_i     = 1'b0;
    cfg_commit_i = 1'b0;
    if (alsoWrite && sel < 3) mSh[sel] = val;
    checkOutput("commit_pending_set", commit_pending_o, 1);
    checkOutput("commit_ready_low", in_ready_o, 0);
    @(posedge clk_i);
    #1;
    checkOutput("commit_pending_clr", commit_pending_o, 0);
    checkOutput("commit_ready_back", in_ready_o, 1);
    mB0 = mSh[0]; mB1 = mSh[1]; mA1 = mSh[2];
  endtask

  task automatic applyStimulus(input int ch, input int data, input int stall,
                               output int gotData, output int gotCh,
                               output int latency, output int acceptCyc);
    int n;
    gotData = 0; gotCh = 0; latency = 0; acceptCyc = 0;
    in_ch_i     = 2'(ch);
    in_data_i   = 16'(data);
    in_valid_i  = 1'b1;
    out_ready_i = (stall == 0);
    n = 0;
    while (!in_ready_o && n < 50) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (!in_ready_o) begin
      checkOutput("accept_timeout", 0, 1);
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      return;
    end
    @(posedge clk_i);
    #1;
    acceptCyc  = cyc;
    in_valid_i = 1'b0;
    n = 1;
    while (!out_valid_o && n < 50) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (!out_valid_o) begin
      checkOutput("output_timeout", 0, 1);
      out_ready_i = 1'b1;
      return;
    end
    latency = n;
    gotData = int'(out_data_o);
    gotCh   = int'(out_ch_o);
    repeat (stall) @(posedge clk_i);
    #1;
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("valid_drop", out_valid_o, 0);
  endtask

  task automatic runSample(input string name, input int ch, input int data,
                           input int stall, input int expData, output int acceptCyc);
    int gotData, gotCh, latency;
    applyStimulus(ch, data, stall, gotData, gotCh, latency, acceptCyc);
    checkOutput({name, "_data"}, gotData, expData);
    checkOutput({name, "_ch"}, gotCh, ch);
    checkOutput({name, "_latency"}, latency, 4);
  endtask

  initial begin
    vec_t tbl [4];
    int   acc0, accPrev, expY;

    tbl[0] = '{ch: 0, data: 1000, expData: 999 + R};
    tbl[1] = '{ch: 1, data: 2000, expData: 1999 + R};
    tbl[2] = '{ch: 0, data: 1000, expData: -1 + R};
    tbl[3] = '{ch: 1, data: 2000, expData: -1 + R};

    doReset();
    checkOutput("rst_pending", commit_pending_o, 0);
    checkOutput("rst_out_data", out_data_o, 0);

    // Interleaved channels with default coefficients, back to back.
    accPrev = 0;
    for (int i = 0; i < 4; i++) begin
      runSample($sformatf("tbl%0d", i), tbl[i].ch, tbl[i].data, 0, tbl[i].expData, acc0);
      if (i > 0) checkOutput($sformatf("tbl%0d_spacing", i), acc0 - accPrev, 5);
      accPrev = acc0;
    end

    $display("[TB] positive saturation");
    doReset();
    writeCoef(0, 131071);
    commitCoefs(1'b1, 1, 131071);
    runSample("satp0", 1, 32767, 0, 32766 + R, acc0);
    runSample("satp1", 1, 32767, 0, 32767, acc0);

    $display("[TB] negative saturation");
    doReset();
    writeCoef(0, -131072);
    commitCoefs(1'b1, 1, -131072);
    runSample("satn0", 1, 32767, 0, -32767, acc0);
    runSample("satn1", 1, 32767, 0, -32768, acc0);

    $display("[TB] recursive impulse");
    doReset();
    writeCoef(0, 65536);
    writeCoef(1, 0);
    commitCoefs(1'b1, 2, 65536);
    runSample("imp0", 2, 16384, 0, 8192, acc0);
    runSample("imp1", 2, 0, 0, 4096, acc0);
    runSample("imp2", 2, 0, 0, 2048, acc0);

    $display("[TB] commit during an active sample");
    doReset();
    in_ch_i = 2'd3; in_data_i = 16'sd1000; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    @(posedge clk_i); #1;
    cfg_sel_i = 2'd0; cfg_data_i = 18'sd65536; cfg_we_i = 1'b1; cfg_commit_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_we_i = 1'b0; cfg_commit_i = 1'b0;
    checkOutput("mid_pending", commit_pending_o, 1);
    @(posedge clk_i); #1;
    checkOutput("mid_valid", out_valid_o, 1);
    checkOutput("mid_data", out_data_o, 999 + R);
    checkOutput("mid_pending_out", commit_pending_o, 1);
    @(posedge clk_i); #1;
    checkOutput("mid_pending_idle", commit_pending_o, 1);
    checkOutput("mid_ready_apply", in_ready_o, 0);
    @(posedge clk_i); #1;
    checkOutput("mid_pending_clr", commit_pending_o, 0);
    runSample("mid_next", 3, 1000, 0, -500, acc0);

    $display("[TB] output stall then reset");
    doReset();
    out_ready_i = 1'b0;
    in_ch_i = 2'd0; in_data_i = 16'sd1000; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("stall%0d_valid", k), out_valid_o, 1);
      checkOutput($sformatf("stall%0d_data", k), out_data_o, 999 + R);
      checkOutput($sformatf("stall%0d_ch", k), out_ch_o, 0);
      checkOutput($sformatf("stall%0d_ready", k), in_ready_o, 0);
      @(posedge clk_i); #1;
    end
    reset_ni = 1'b0;
    #1;
    checkOutput("async_rst_valid", out_valid_o, 0);
    checkOutput("async_rst_data", out_data_o, 0);
    checkOutput("async_rst_ch", out_ch_o, 0);
    checkOutput("async_rst_ready", in_ready_o, 0);
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    modelReset();
    runSample("hist_cleared", 0, 1000, 0, 999 + R, acc0);

    $display("[TB] randomized run against reference model");
    doReset();
    writeCoef(0, int'($urandom_range(0, 262143)) - 131072);
    writeCoef(1, int'($urandom_range(0, 262143)) - 131072);
    writeCoef(3, int'($urandom_range(0, 262143)) - 131072);
    commitCoefs(1'b1, 2, int'($urandom_range(0, 131071)) - 65536);
    for (int i = 0; i < 24; i++) begin
      int ch, x;
      ch   = int'($urandom_range(0, 3));
      x    = int'($urandom_range(0, 65535)) - 32768;
      expY = modelStep(ch, x);
      runSample($sformatf("rnd%0d", i), ch, x, int'($urandom_range(0, 3)), expY, acc0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_sched.md
Name: fir_mac_sched

Overview:
- Time-multiplexed scheduler for a first-order IIR/FIR section built around one shared signed 18x16 multiplier.
- Serves NUM_CH independent channels and computes y[n] = sat(b0*x[n] + b1*x[n-1] + a1*y[n-1]) per accepted sample.
- Sequences the three products through an FSM and keeps per-channel history.
- Owns the coefficient registers, with shadow/commit so a sample never mixes coefficient sets.

Parameters:
- NUM_CH, 4, number of channels; must be a power of two, CH_W = $clog2(NUM_CH) (min 1).
- INOUT_WIDTH, 16, sample width, signed Q1.15.
- INTERNAL_WIDTH, 18, coefficient and accumulator width, coefficients signed Q1.17.
- COEF_B0_RST, 18'sd131071, reset value of active/shadow b0.
- COEF_B1_RST, -18'sd131072, reset value of active/shadow b1.
- COEF_A1_RST, 18'sd0, reset value of active/shadow a1.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  input sample valid.
- in_ready_o  out  1  scheduler can accept a sample.
- in_ch_i  in  CH_W  channel of input sample.
- in_data_i  in  INOUT_WIDTH  signed input sample.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts result.
- out_ch_o  out  CH_W  channel of result.
- out_data_o  out  INOUT_WIDTH  signed saturated result.
- cfg_we_i  in  1  shadow coefficient write strobe.
- cfg_sel_i  in  2  0=b0, 1=b1, 2=a1, 3=ignored.
- cfg_data_i  in  INTERNAL_WIDTH  signed coefficient value.
- cfg_commit_i  in  1  request copy of shadow to active.
- commit_pending_o  out  1  commit requested, not yet applied.

Behaviour:
- Reset (async assert, sync release):
  - FSM to IDLE.
  - All outputs 0; in_ready_o=1 after release.
  - Per-channel x1/y1 history cleared to 0.
  - Active and shadow coefficients loaded with the *_RST values; pending flag cleared.
  - Reset mid-sample discards the sample with no output.
- FSM states:
  - IDLE: in_ready_o=1. On in_valid_i&in_ready_o, latch ch/data and go to MUL_B0.
  - MUL_B0: acc = sat18(term(b0,x)); go to MUL_B1.
  - MUL_B1: acc = sat18(acc + term(b1,x1[ch])); go to MUL_A1.
  - MUL_A1: acc = sat18(acc + term(a1,y1[ch])); go to OUT.
  - OUT, on entry: out_data_o=sat16(acc), out_ch_o=ch, out_valid_o=1, x1[ch]<=x, y1[ch]<=out_data_o. Hold all until out_ready_i; then out_valid_o=0 and go to IDLE.
- Latency: accept at cycle 0, out_valid_o at cycle 4. Peak throughput is one sample per 5 cycles with out_ready_i held high.
- in_ready_o=0 in every state except IDLE. Output fields must stay stable while out_valid_o=1 and out_ready_i=0.
- Arithmetic:
  - Product is signed INOUT_WIDTH+INTERNAL_WIDTH bits.
  - term = product >>> (INTERNAL_WIDTH-1), arithmetic shift, floor rounding, result in sample LSB units.
  - Sums use INTERNAL_WIDTH+1 bits, then clamp to [-2^17, 2^17-1].
  - Final clamp to [-32768, 32767].
- Coefficients:
  - cfg_we_i writes the shadow register immediately, in any state.
  - cfg_commit_i sets the pending flag; a same-cycle cfg_we_i is included in the commit.
  - The pending copy is applied on a cycle with FSM in IDLE; it has priority over accept in that cycle, so in_ready_o=0 for that one cycle.
  - Commit in IDLE with no sample therefore applies next cycle.
  - commit_pending_o falls when the copy is applied.
  - Active coefficients are only read in the MUL states and never change between MUL_B0 and OUT.
- Channels are fully independent; history is touched only for the processed channel.

Optional Feature:
- Macro: FIR_MAC_SCHED_ROUND_EN.
- Defined: each term adds 2^(INTERNAL_WIDTH-2) to the product before the shift (round half up).
- Undefined: plain floor (truncating arithmetic shift).
- Latency and ports are identical in both cases.

Test Plan:
- Default coefficients, ch0 inputs 1000 then 1000, out_ready_i=1 -> out 999 then -1, each 4 cycles after accept. With FIR_MAC_SCHED_ROUND_EN: 1000 then 0.
- Program b0=b1=131071, commit, ch1 inputs 32767, 32767 -> second output clamps to 32767. Negative case: b0=b1=-131072, inputs 32767, 32767 -> -32768.
- Program b0=65536, b1=0, a1=65536; ch2 impulse 16384 then 0, 0 -> outputs 8192, 4096, 2048.
- Interleave ch0=1000, ch1=2000, ch0=1000, ch1=2000 with default coefficients -> 999, 1999, -1, -1, with out_ch_o matching each input.
- Write b0=65536 and pulse cfg_commit_i during MUL_B1 of a ch3 sample x=1000 (defaults) -> that output is 999. commit_pending_o stays 1 until IDLE. The next ch3 sample 1000 yields 500 + (-1000) = -500.
- Hold out_ready_i=0 for 10 cycles with a result pending -> out_valid_o, out_data_o, out_ch_o stable and in_ready_o=0. Then assert reset_ni=0 mid-wait -> all outputs 0 immediately, history cleared.
